// File: rtl/daq_frame_checker_if.sv
// rtl/daq_frame_checker_if.sv - DAQ readout word stream into the frame checker
interface daq_frame_checker_if;
   logic [18:0] daqp;

   modport master (output daqp);
   modport slave  (input  daqp);
endinterface

// File: rtl/daq_frame_checker.sv
// rtl/daq_frame_checker.sv - ALCT DAQ frame parser/checker; CRC-22 check built only with DAQ_FRAME_CHECKER_CRC_EN
module daq_frame_checker #(
   parameter int CNT_W     = 16,
   parameter int MAX_WORDS = 2047
) (
   input  logic               clk,
   input  logic               hard_rst,
   daq_frame_checker_if.slave daq,
   output logic [11:0]        hdr_bxn,
   output logic [11:0]        hdr_l1a_cnt,
   output logic [11:0]        hdr_rd_cnt,
   output logic [3:0]         hdr_lct_bins,
   output logic [4:0]         hdr_raw_bins,
   output logic               hdr_cfg,
   output logic               hdr_zs,
   output logic               frame_done,
   output logic               frame_ok,
   output logic [4:0]         err,
   output logic [CNT_W-1:0]   good_cnt,
   output logic [CNT_W-1:0]   bad_cnt
);
   // word index width: must hold MAX_WORDS+1 and at least the 11-bit trailer count
   localparam int NW = ($clog2(MAX_WORDS + 2) > 12) ? $clog2(MAX_WORDS + 2) : 12;

   localparam logic [18:0]      W_START = 19'h0DB0A;
   localparam logic [18:0]      W_BEND  = 19'h0DE0D;
   localparam logic [18:0]      W_PAD   = 19'h03000;
   localparam logic [NW-1:0]    ONE_N   = NW'(1);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_CRC0, S_CRC1, S_TRL} state_t;

   state_t         state;
   logic [18:0]    w;
   logic [NW-1:0]  n;
   logic [NW-1:0]  n_next;
   logic [NW-1:0]  body_cnt;
   logic [NW-1:0]  pad_run;
   logic [NW-1:0]  body_nonpad;
   logic [NW-1:0]  len_min;
   logic [NW-1:0]  len_full;
   logic [4:0]     err_acc;
   logic [4:0]     err_word;
   logic [4:0]     err_final;
   logic           abort;

   assign w           = daq.daqp;
   assign n_next      = n + ONE_N;
   assign err_final   = err_acc | err_word;
   // idle words or a runaway frame end whatever frame is in progress
   assign abort       = (state != S_IDLE) && (w[18] || (n_next > NW'(MAX_WORDS)));

   // expected body size from the latched header; trailing pad words are not data
   assign body_nonpad = body_cnt - pad_run;
   assign len_min     = (hdr_cfg ? NW'(96) : NW'(0)) + NW'({hdr_lct_bins, 1'b0});
   assign len_full    = len_min + NW'(hdr_raw_bins) * NW'(60);

`ifdef DAQ_FRAME_CHECKER_CRC_EN
   logic [21:0] crc;
   logic [21:0] crc_next;

   // CRC-22, x^22+x+1, MSB first over the low 16 bits of one word
   function automatic logic [21:0] crc22_step16(input logic [21:0] c, input logic [15:0] d);
      logic [21:0] r;
      logic        fb;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         fb = r[21] ^ d[i];
         r  = {r[20:0], fb} ^ {20'd0, fb, 1'b0};
      end
      return r;
   endfunction

   // the start word seeds a fresh CRC from zero
   assign crc_next = crc22_step16((state == S_IDLE) ? 22'd0 : crc, w[15:0]);
`endif

   // error bits raised by the word currently on daqp
   always_comb begin
      err_word = '0;
      case (state)
         S_HDR: begin
            if ((n_next == NW'(2) || n_next == NW'(3) || n_next == NW'(4)) && w[18:12] != 7'h0D)
               err_word[0] = 1'b1;
            if (n_next == NW'(5) && w[18:15] != 4'h0)
               err_word[0] = 1'b1;
            if (n_next == NW'(6) && w[18:13] != 6'h00)
               err_word[0] = 1'b1;
            if (n_next == NW'(8) && (w[18:15] != 4'h0 || w[14:9] != 6'h05))
               err_word[0] = 1'b1;
         end
         S_BODY: begin
            if (w == W_BEND) begin
               if (!hdr_zs) begin
                  if (body_nonpad != len_full || pad_run > NW'(3))
                     err_word[2] = 1'b1;
               end else if (body_nonpad < len_min) begin
                  err_word[2] = 1'b1;
               end
            end
         end
`ifdef DAQ_FRAME_CHECKER_CRC_EN
         S_CRC0: if (w != {8'h00, crc[10:0]})  err_word[3] = 1'b1;
         S_CRC1: if (w != {8'h00, crc[21:11]}) err_word[3] = 1'b1;
`endif
         S_TRL: begin
            if (w[18:11] != 8'b0011_1010)  err_word[0] = 1'b1;
            if (w[10:0] != n_next[10:0])   err_word[4] = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef DAQ_FRAME_CHECKER_CRC_EN
   // running CRC over start word through body-end word
   always_ff @(posedge clk) begin
      if (hard_rst)
         crc <= '0;
      else if ((state == S_IDLE && w == W_START) ||
               (!abort && (state == S_HDR || state == S_BODY)))
         crc <= crc_next;
   end
`endif

   // frame FSM: header latch, body counting, end-of-frame status and counters
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         state        <= S_IDLE;
         n            <= '0;
         body_cnt     <= '0;
         pad_run      <= '0;
         err_acc      <= '0;
         hdr_bxn      <= '0;
         hdr_l1a_cnt  <= '0;
         hdr_rd_cnt   <= '0;
         hdr_lct_bins <= '0;
         hdr_raw_bins <= '0;
         hdr_cfg      <= 1'b0;
         hdr_zs       <= 1'b0;
         frame_done   <= 1'b0;
         frame_ok     <= 1'b0;
         err          <= '0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
      end else begin
         frame_done <= 1'b0;
         if (state == S_IDLE) begin
            if (w == W_START) begin
               state    <= S_HDR;
               n        <= ONE_N;
               body_cnt <= '0;
               pad_run  <= '0;
               err_acc  <= '0;
            end
         end else if (abort) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
            frame_ok   <= 1'b0;
            err        <= err_acc | 5'b00010;
            if (bad_cnt != '1) bad_cnt <= bad_cnt + ONE_C;
         end else begin
            n       <= n_next;
            err_acc <= err_final;
            case (state)
               S_HDR: begin
                  if (n_next == NW'(2)) hdr_bxn     <= w[11:0];
                  if (n_next == NW'(3)) hdr_l1a_cnt <= w[11:0];
                  if (n_next == NW'(4)) hdr_rd_cnt  <= w[11:0];
                  if (n_next == NW'(5)) hdr_cfg     <= w[14];
                  if (n_next == NW'(6)) hdr_zs      <= w[12];
                  if (n_next == NW'(8)) begin
                     hdr_lct_bins <= w[8:5];
                     hdr_raw_bins <= w[4:0];
                     state        <= S_BODY;
                  end
               end
               S_BODY: begin
                  if (w == W_BEND) begin
                     state <= S_CRC0;
                  end else begin
                     body_cnt <= body_cnt + ONE_N;
                     pad_run  <= (w == W_PAD) ? pad_run + ONE_N : '0;
                  end
               end
               S_CRC0: state <= S_CRC1;
               S_CRC1: state <= S_TRL;
               S_TRL: begin
                  state      <= S_IDLE;
                  frame_done <= 1'b1;
                  frame_ok   <= ~|err_final;
                  err        <= err_final;
                  if (~|err_final) begin
                     if (good_cnt != '1) good_cnt <= good_cnt + ONE_C;
                  end else begin
                     if (bad_cnt != '1) bad_cnt <= bad_cnt + ONE_C;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_daq_frame_checker.sv
// tb/tb_daq_frame_checker.sv - randomized self-checking bench for daq_frame_checker
module tb_daq_frame_checker;
   localparam int CNT_W     = 4;
   localparam int MAX_WORDS = 2047;
   localparam int MAX_CNT   = (1 << CNT_W) - 1;

   typedef logic [18:0] wq_t[$];
   typedef struct {
      logic [4:0]  err;
      bit          hdr_ok;
      logic [11:0] bxn;
      logic [11:0] l1a;
      logic [11:0] rd;
      logic [3:0]  lct;
      logic [4:0]  raw;
      logic        cfg;
      logic        zs;
      int          good;
      int          bad;
   } exp_t;

   logic             clk = 1'b0;
   logic             hard_rst;
   logic [11:0]      hdr_bxn, hdr_l1a_cnt, hdr_rd_cnt;
   logic [3:0]       hdr_lct_bins;
   logic [4:0]       hdr_raw_bins;
   logic             hdr_cfg, hdr_zs, frame_done, frame_ok;
   logic [4:0]       err;
   logic [CNT_W-1:0] good_cnt, bad_cnt;

   daq_frame_checker_if dif ();

   daq_frame_checker #(.CNT_W(CNT_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk          (clk),
      .hard_rst     (hard_rst),
      .daq          (dif),
      .hdr_bxn      (hdr_bxn),
      .hdr_l1a_cnt  (hdr_l1a_cnt),
      .hdr_rd_cnt   (hdr_rd_cnt),
      .hdr_lct_bins (hdr_lct_bins),
      .hdr_raw_bins (hdr_raw_bins),
      .hdr_cfg      (hdr_cfg),
      .hdr_zs       (hdr_zs),
      .frame_done   (frame_done),
      .frame_ok     (frame_ok),
      .err          (err),
      .good_cnt     (good_cnt),
      .bad_cnt      (bad_cnt)
   );

   always #12 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_good   = 0;
   int   m_bad    = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] idle_word();
      return {1'b1, 18'($urandom)};
   endfunction

   function automatic logic [18:0] rnd_body();
      logic [18:0] v;
      do v = {1'b0, 18'($urandom)}; while (v == 19'h0DE0D || v == 19'h03000);
      return v;
   endfunction

   // CRC as polynomial long division of the augmented message
   function automatic logic [21:0] crc_of(input wq_t f, input int last);
      logic [22:0] r;
      r = '0;
      for (int i = 0; i <= last; i++)
         for (int b = 15; b >= 0; b--) begin
            r = {r[21:0], 1'b0} ^ {f[i][b], 22'd0};
            if (r[22]) r = r ^ 23'h400003;
         end
      return r[21:0];
   endfunction

   function automatic int exp_len(input logic cfg, input logic [3:0] lct, input logic [4:0] raw);
      return (cfg ? 96 : 0) + ((lct != 0) ? 2 * (int'(lct) - 1) + 2 : 0) + 60 * int'(raw);
   endfunction

   function automatic wq_t build_frame(input logic [11:0] bxn, input logic [11:0] l1a,
                                       input logic [11:0] rd, input logic cfg, input logic zs,
                                       input logic [3:0] lct, input logic [4:0] raw,
                                       input int nb, input int pad);
      wq_t f;
      logic [21:0] c;
      f.push_back(19'h0DB0A);
      f.push_back({7'h0D, bxn});
      f.push_back({7'h0D, l1a});
      f.push_back({7'h0D, rd});
      f.push_back({4'h0, cfg, 14'($urandom)});
      f.push_back({6'h00, zs, 12'($urandom)});
      f.push_back({1'b0, 18'($urandom)});
      f.push_back({4'h0, 6'h05, lct, raw});
      repeat (nb) f.push_back(rnd_body());
      repeat (pad) f.push_back(19'h03000);
      f.push_back(19'h0DE0D);
      c = crc_of(f, f.size() - 1);
      f.push_back({8'h00, c[10:0]});
      f.push_back({8'h00, c[21:11]});
      f.push_back({8'b0011_1010, 11'(f.size() + 1)});
      return f;
   endfunction

   function automatic bit hdr_bad(input int idx, input logic [18:0] x);
      case (idx)
         2, 3, 4: return x[18:12] != 7'h0D;
         5:       return x[18:15] != 4'h0;
         6:       return x[18:13] != 6'h00;
         8:       return (x[18:15] != 4'h0) || (x[14:9] != 6'h05);
         default: return 1'b0;
      endcase
   endfunction

   // whole-frame reference: inspects the complete word list at once
   function automatic exp_t model(input wq_t f);
      exp_t e;
      int   k, d, last_hdr, pad, nonpad;
      logic [21:0] c;
      logic [18:0] tr;
      e = '{err: 5'd0, hdr_ok: 1'b0, bxn: 12'd0, l1a: 12'd0, rd: 12'd0, lct: 4'd0,
            raw: 5'd0, cfg: 1'b0, zs: 1'b0, good: 0, bad: 0};
      k = -1;
      d = -1;
      for (int i = 1; i < f.size(); i++)
         if (k < 0 && (f[i][18] || i + 1 > MAX_WORDS)) k = i;
      last_hdr = (k < 0) ? 7 : ((k - 1 < 7) ? k - 1 : 7);
      for (int i = 1; i <= last_hdr; i++)
         if (hdr_bad(i + 1, f[i])) e.err[0] = 1'b1;
      e.hdr_ok = (k < 0) || (k >= 8);
      if (e.hdr_ok) begin
         e.bxn = f[1][11:0]; e.l1a = f[2][11:0]; e.rd = f[3][11:0];
         e.cfg = f[4][14];   e.zs  = f[5][12];
         e.lct = f[7][8:5];  e.raw = f[7][4:0];
      end
      if (k >= 0) begin
         e.err[1] = 1'b1;
         return e;
      end
      for (int i = 8; i < f.size(); i++)
         if (d < 0 && f[i] == 19'h0DE0D) d = i;
      pad = 0;
      while (d - 1 - pad >= 8 && f[d - 1 - pad] == 19'h03000) pad++;
      nonpad = d - 8 - pad;
      if (!e.zs) begin
         if (nonpad != exp_len(e.cfg, e.lct, e.raw) || pad > 3) e.err[2] = 1'b1;
      end else if (nonpad < exp_len(e.cfg, e.lct, 5'd0)) begin
         e.err[2] = 1'b1;
      end
`ifdef DAQ_FRAME_CHECKER_CRC_EN
      c = crc_of(f, d);
      if (f[d + 1] != {8'h00, c[10:0]} || f[d + 2] != {8'h00, c[21:11]}) e.err[3] = 1'b1;
`else
      c = '0;
`endif
      tr = f[d + 3];
      if (tr[18:11] != 8'b0011_1010) e.err[0] = 1'b1;
      if (tr[10:0] != 11'(d + 4) || c[0] === 1'bx) e.err[4] = 1'b1;
      return e;
   endfunction

   task automatic send_frame(input wq_t f, input int gap);
      exp_t e;
      e = model(f);
      if (e.err == 5'd0) begin
         if (m_good < MAX_CNT) m_good++;
      end else if (m_bad < MAX_CNT) begin
         m_bad++;
      end
      e.good = m_good;
      e.bad  = m_bad;
      exp_q.push_back(e);
      foreach (f[i]) begin
         @(negedge clk);
         dif.daqp = f[i];
      end
      repeat (gap) begin
         @(negedge clk);
         dif.daqp = idle_word();
      end
   endtask

   // compares each completed frame against the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(frame_done), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("err", 32'(err), 32'(mon_e.err));
               check("frame_ok", 32'(frame_ok), 32'(mon_e.err == 5'd0));
               if (mon_e.hdr_ok) begin
                  check("hdr_bxn", 32'(hdr_bxn), 32'(mon_e.bxn));
                  check("hdr_l1a_cnt", 32'(hdr_l1a_cnt), 32'(mon_e.l1a));
                  check("hdr_rd_cnt", 32'(hdr_rd_cnt), 32'(mon_e.rd));
                  check("hdr_lct_bins", 32'(hdr_lct_bins), 32'(mon_e.lct));
                  check("hdr_raw_bins", 32'(hdr_raw_bins), 32'(mon_e.raw));
                  check("hdr_cfg", 32'(hdr_cfg), 32'(mon_e.cfg));
                  check("hdr_zs", 32'(hdr_zs), 32'(mon_e.zs));
               end
               @(negedge clk);
               check("done_pulse", 32'(frame_done), 32'd0);
               check("good_cnt", 32'(good_cnt), 32'(mon_e.good));
               check("bad_cnt", 32'(bad_cnt), 32'(mon_e.bad));
            end
         end
      end
   end

   initial begin
      wq_t  f, g;
      logic [11:0] bxn, l1a, rd;
      logic cfg, zs;
      logic [3:0] lct;
      logic [4:0] raw;
      int   nb, pad, kind, wait_cnt;

      hard_rst = 1'b1;
      dif.daqp = idle_word();
      repeat (3) @(negedge clk);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_ok", 32'(frame_ok), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_good", 32'(good_cnt), 32'd0);
      check("rst_bad", 32'(bad_cnt), 32'd0);
      check("rst_bxn", 32'(hdr_bxn), 32'd0);
      hard_rst = 1'b0;

      // clean reference frame, then the same with a bad word-3 prefix, back to back
      f = build_frame(12'hABC, 12'h123, 12'h456, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      send_frame(f, 0);
      f = build_frame(12'h5A5, 12'h001, 12'h002, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      f[2] = {7'h0C, f[2][11:0]};
      send_frame(f, 1);

      // idle word at body word 50, followed by a clean frame
      f = build_frame(12'h777, 12'h010, 12'h020, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      g.delete();
      for (int i = 0; i < 57; i++) g.push_back(f[i]);
      g.push_back(19'h40000);
      send_frame(g, 0);
      f = build_frame(12'h778, 12'h011, 12'h021, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      send_frame(f, 2);

      // trailer count off by one; one body bit flipped after CRC generation
      f = build_frame(12'h100, 12'h200, 12'h300, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      f[f.size() - 1] = f[f.size() - 1] + 19'd1;
      send_frame(f, 1);
      f = build_frame(12'h101, 12'h201, 12'h301, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      f[20] = f[20] ^ 19'h00100;
      send_frame(f, 1);

      // length rules: one word short, zero-suppressed short frame, padding limits, cfg-only
      f = build_frame(12'h102, 12'h202, 12'h302, 1'b0, 1'b0, 4'd3, 5'd2, 125, 2);
      send_frame(f, 1);
      f = build_frame(12'h103, 12'h203, 12'h303, 1'b0, 1'b1, 4'd3, 5'd2, 46, 0);
      send_frame(f, 1);
      f = build_frame(12'h104, 12'h204, 12'h304, 1'b0, 1'b0, 4'd3, 5'd2, 126, 4);
      send_frame(f, 1);
      f = build_frame(12'h105, 12'h205, 12'h305, 1'b0, 1'b0, 4'd3, 5'd2, 126, 3);
      send_frame(f, 1);
      f = build_frame(12'h106, 12'h206, 12'h306, 1'b1, 1'b0, 4'd0, 5'd0, 96, 0);
      send_frame(f, 1);

      // runaway frame: no body-end word before the watchdog limit
      f = build_frame(12'h107, 12'h207, 12'h307, 1'b0, 1'b0, 4'd3, 5'd2, 0, 0);
      g.delete();
      for (int i = 0; i < 8; i++) g.push_back(f[i]);
      while (g.size() < MAX_WORDS + 1) g.push_back(rnd_body());
      send_frame(g, 2);

      // randomized frames with assorted corruptions
      for (int t = 0; t < 12; t++) begin
         bxn  = 12'($urandom);
         l1a  = 12'($urandom);
         rd   = 12'($urandom);
         cfg  = 1'($urandom_range(0, 1));
         zs   = 1'($urandom_range(0, 1));
         lct  = 4'($urandom);
         raw  = 5'($urandom_range(0, 20));
         nb   = exp_len(cfg, lct, raw);
         pad  = $urandom_range(0, 3);
         kind = $urandom_range(0, 5);
         if (kind == 1) nb = nb + 1;
         if (kind == 2 && nb > 0) nb = nb - 1;
         f = build_frame(bxn, l1a, rd, cfg, zs, lct, raw, nb, pad);
         if (kind == 3) f[f.size() - 1] = f[f.size() - 1] ^ 19'h00001;
         if (kind == 4) begin
            nb = $urandom_range(1, 7);
            f[nb] = f[nb] ^ 19'h20000;
         end
         if (kind == 5 && f.size() > 12) f[8] = f[8] ^ 19'h00001;
         send_frame(f, $urandom_range(0, 2));
      end

      // reset in the middle of a frame drops it; counters restart from zero
      repeat (4) begin
         @(negedge clk);
         dif.daqp = idle_word();
      end
      f = build_frame(12'h321, 12'h654, 12'h987, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         dif.daqp = f[i];
      end
      @(negedge clk);
      hard_rst = 1'b1;
      dif.daqp = idle_word();
      @(negedge clk);
      check("mid_rst_good", 32'(good_cnt), 32'd0);
      check("mid_rst_bad", 32'(bad_cnt), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_bxn", 32'(hdr_bxn), 32'd0);
      hard_rst = 1'b0;
      m_good = 0;
      m_bad  = 0;
      f = build_frame(12'h322, 12'h655, 12'h988, 1'b0, 1'b0, 4'd3, 5'd2, 126, 2);
      send_frame(f, 2);

      // drive the bad counter past saturation
      for (int i = 0; i < MAX_CNT + 6; i++) begin
         g.delete();
         g.push_back(19'h0DB0A);
         g.push_back(19'h40000);
         send_frame(g, 1);
      end

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 200) begin
         @(negedge clk);
         wait_cnt++;
      end
      repeat (3) @(negedge clk);
      check("pending_frames", 32'(exp_q.size()), 32'd0);
      check("bad_cnt_sat", 32'(bad_cnt), 32'(MAX_CNT));
      check("good_cnt_final", 32'(good_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/daq_frame_checker.md
# daq_frame_checker

Receive-side parser and checker for the 19-bit ALCT DAQ readout stream (`daqp`). Sits on the DAQ output path in simulation and board-test builds, and in optional on-chip loopback builds. Detects each frame and extracts the header fields. Checks framing, length, frame-count and CRC, then reports per-frame status and saturating good/bad frame counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the good/bad frame counters (saturating).
- `MAX_WORDS`, default 2047: watchdog limit; a frame longer than this is aborted.

Ports:
- `clk` in 1: 40 MHz system clock; all logic on the rising edge.
- `hard_rst` in 1: reset, synchronous and active-high.
- `daqp` in 19: DAQ word, one per clock. Bit 18 = 1 marks an idle word.
- `hdr_bxn` out 12: BXN from header word 2.
- `hdr_l1a_cnt` out 12: L1A count from header word 3.
- `hdr_rd_cnt` out 12: readout count from header word 4.
- `hdr_lct_bins` out 4: lct_bins_report field from header word 8.
- `hdr_raw_bins` out 5: raw_bins field from header word 8.
- `hdr_cfg` out 1: config_report flag (word 5 bit 14).
- `hdr_zs` out 1: zero_suppress flag (word 6 bit 12).
- `frame_done` out 1: one-cycle pulse after the last frame word.
- `frame_ok` out 1: valid with `frame_done`; high when no error flag is set.
- `err` out 5: sticky per frame, valid with `frame_done`. Bits: [0] header, [1] truncation/idle, [2] length, [3] CRC, [4] frame-count.
- `good_cnt` out CNT_W: count of good frames.
- `bad_cnt` out CNT_W: count of bad frames.

## Operation
- Word index n counts from 1 at 0x0DB0A.
- States: IDLE, HDR, BODY, CRC0, CRC1, TRL.
- IDLE:
  - Non-idle word == 0x0DB0A → HDR, n=1, CRC cleared then updated.
  - Any other non-idle word is ignored.
- HDR, words 2–8:
  - Words 2–4: bits[18:12] must be 0x0D.
  - Word 5: bits[18:15] must be 0.
  - Word 6: bits[18:13] must be 0.
  - Word 7 is not checked.
  - Word 8: bits[18:15]=0 and bits[14:9]=6'h5.
  - Any violation sets err[0]. Fields are latched regardless.
  - After word 8 → BODY.
- BODY expected lengths:
  - E_cfg = 96 if hdr_cfg, else 0.
  - E_lct = 2·(lct_bins_report−1)+2 if lct_bins_report≠0, else 0.
  - E_raw = 60·raw_bins.
- BODY: counts words until 0x0DE0D is seen, then → CRC0. 0x0DE0D cannot occur in body data.
- Trailing 0x03000 words are counted as padding (0–3).
- When hdr_zs=0: set err[2] unless body_nonpad == E_cfg+E_lct+E_raw and padding ≤ 3.
- When hdr_zs=1: set err[2] only if body_nonpad < E_cfg+E_lct.
- CRC0, CRC1: see Configuration. → TRL.
- TRL:
  - bits[18:11] must be 8'b00111010, else err[0].
  - bits[10:0] must equal n mod 2048, where n includes the trailer word itself; else err[4].
  - → IDLE with frame_done.
- Abort conditions:
  - An idle word in any non-IDLE state sets err[1], ends the frame (frame_done, frame_ok=0) and → IDLE.
  - n > MAX_WORDS has the same effect.
- Counters:
  - good_cnt increments when frame_done & frame_ok.
  - bad_cnt increments when frame_done & !frame_ok.
  - Both saturate at all-ones.

## Timing
- Registered outputs. frame_done rises 1 cycle after the trailer or abort word is sampled.
- hdr_* update 1 cycle after their word and hold until the next frame's word.
- A frame start (0x0DB0A) in the cycle right after the trailer is accepted; back-to-back frames need no idle gap.
- 0x0DB0A seen inside HDR/BODY is treated as a body word. Header checks catch the misalignment.
- While hard_rst=1 at a clock edge:
  - state=IDLE.
  - All outputs, counters, err and CRC are 0.
  - Reset mid-frame drops the frame silently; no frame_done and no counter change.

## Configuration
- `DAQ_FRAME_CHECKER_CRC_EN`
  - Defined:
    - CRC-22, polynomial x^22+x+1, init 0, MSB first.
    - Covers bits[15:0] of words 1 through 0x0DE0D inclusive.
    - CRC0 must equal {8'b0, crc[10:0]}; CRC1 must equal {8'b0, crc[21:11]}.
    - A mismatch sets err[3].
  - Undefined: CRC0/CRC1 are consumed unchecked; err[3] is tied to 0 and no CRC logic is built.

## Test plan
- Clean frame, cfg=0, lct_bins_report=3, raw_bins=2, zs=0: 8 + 6 + 120 + pad 2 + 4 words → frame_done, frame_ok=1, err=0, good_cnt=1, hdr_bxn matches the sent value.
- Same frame with word 3 bits[18:12]=0x0C → err[0]=1, bad_cnt=1.
- Idle word (0x40000) injected at body word 50 → frame_done next cycle, err[1]=1; the following clean frame gives frame_ok=1.
- Trailer count field off by one → err[4]=1. With CRC_EN, one body bit flipped → err[3]=1 only.
- zs=0, one raw word removed → err[2]=1. With zs=1 and 40 raw words → frame_ok=1.
- hard_rst asserted at body word 20, then a clean frame: no frame_done for the first frame, good_cnt=1 after the second. With 2^CNT_W+5 bad frames, bad_cnt holds at all-ones.
